// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out transmitter.
// A WIDTH-bit word is accepted via valid/ready. It is shifted out on q_o one bit
// per divider tick, framed by frame_o, and followed by a one-cycle done_o pulse.
// Optional build macro: PISO_LSB_FIRST_EN (LSB first; default is MSB first).
module piso_tx #(
  parameter int WIDTH = 4,
  parameter int DIV   = 25000000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             q_o,
  output logic             frame_o,
  output logic             done_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [BW-1:0]    bcnt, bcnt_nxt;
  logic [CW-1:0]    dcnt;
  logic             tick, accept, out_bit;

  assign tick   = (dcnt == CW'(DIV - 1));
  assign accept = valid_i && (state == IDLE);

`ifdef PISO_LSB_FIRST_EN
  assign out_bit = sr[0];
`else
  assign out_bit = sr[WIDTH-1];
`endif

  // All outputs decode from state and shift-register flops only.
  assign ready_o = (state == IDLE);
  assign frame_o = (state == SHIFT);
  assign done_o  = (state == DONE);
  assign q_o     = (state == SHIFT) && out_bit;

  // Bit-rate divider; restarts on accept so bit 0 gets a full DIV cycles.
  always_ff @(posedge clk_i) begin
    if (!rst_i)               dcnt <= '0;
    else if (accept || tick)  dcnt <= '0;
    else                      dcnt <= dcnt + CW'(1);
  end

  // State, shift register and bit counter.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      sr    <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  // Next-state logic: load on accept, shift per tick, one-cycle DONE.
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    bcnt_nxt  = bcnt;
    unique case (state)
      IDLE: begin
        if (valid_i) begin
          sr_nxt    = data_i;
          bcnt_nxt  = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bcnt == BW'(WIDTH - 1)) begin
            sr_nxt    = '0;
            state_nxt = DONE;
          end else begin
`ifdef PISO_LSB_FIRST_EN
            sr_nxt   = sr >> 1;
`else
            sr_nxt   = sr << 1;
`endif
            bcnt_nxt = bcnt + BW'(1);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx (WIDTH=4, DIV=3). Stimulus pushes the expected
// serial sequence (bit [3] sent first); a monitor checks each observed frame.
module tb_piso_tx;
  localparam int WIDTH = 4;
  localparam int DIV   = 3;
  localparam int NS    = WIDTH * DIV;

  typedef struct {
    logic [WIDTH-1:0] bits;
    bit               abort;
    bit               b2b;
  } exp_t;

  logic clk = 0;
  logic rst_i, valid_i;
  logic [WIDTH-1:0] data_i;
  logic ready_o, q_o, frame_o, done_o;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

`ifdef PISO_LSB_FIRST_EN
  localparam logic [3:0] S_1011 = 4'b1101;
  localparam logic [3:0] S_1100 = 4'b0011;
`else
  localparam logic [3:0] S_1011 = 4'b1011;
  localparam logic [3:0] S_1100 = 4'b1100;
`endif
  localparam logic [3:0] S_1001 = 4'b1001;
  localparam logic [3:0] S_0110 = 4'b0110;
  localparam logic [3:0] S_1111 = 4'b1111;

  piso_tx #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .q_o(q_o), .frame_o(frame_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [3:0] b, input bit ab, input bit bb);
    exp_t e;
    e.bits = b; e.abort = ab; e.b2b = bb;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL wait_ready: ready_o stayed low for %0d cycles", n);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic [3:0] s, input bit ab);
    wait_ready();
    valid_i = 1'b1;
    data_i  = d;
    push(s, ab, 1'b0);
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  // Monitor: capture frames at negedge, compare against scoreboard on frame end.
  initial begin
    logic [0:NS-1] smp;
    int fcnt = 0, gap = 0, rlow = 0;
    bit prev_frame = 0, prev_ready = 1, last_abort = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_o === 1'b1) begin
        if (!prev_frame && sb.size() > 0 && sb[0].b2b) begin
          tests++;
          if (gap != 2) begin
            fails++;
            $display("FAIL b2b_gap: got %0d idle cycles, expected 2", gap);
          end
        end
        if (fcnt < NS) smp[fcnt] = q_o;
        fcnt++;
      end else if (prev_frame) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_frame: got a frame of %0d cycles, expected none", fcnt);
        end else begin
          e = sb.pop_front();
          if (e.abort) begin
            chk("abort_done", done_o, 1'b0);
            chk("abort_ready", ready_o, 1'b1);
            chk("abort_q", q_o, 1'b0);
            last_abort = 1;
          end else begin
            tests++;
            if (fcnt != NS) begin
              fails++;
              $display("FAIL frame_len: got %0d, expected %0d", fcnt, NS);
            end
            chk("done_pulse", done_o, 1'b1);
            chk("done_q", q_o, 1'b0);
            for (int k = 0; k < WIDTH; k++) begin
              tests++;
              for (int j = 0; j < DIV; j++) begin
                if (smp[k*DIV+j] !== e.bits[WIDTH-1-k]) begin
                  fails++;
                  $display("FAIL bit%0d: got %b in sample %0d, expected %b",
                           k, smp[k*DIV+j], j, e.bits[WIDTH-1-k]);
                  break;
                end
              end
            end
            last_abort = 0;
          end
        end
        fcnt = 0;
        gap  = 1;
      end else begin
        gap++;
      end
      if (done_o === 1'b1 && !(prev_frame && frame_o === 1'b0)) begin
        tests++; fails++;
        $display("FAIL stray_done: got done_o=1, expected 0 at %0t", $time);
      end
      if (ready_o === 1'b0) rlow++;
      else if (ready_o === 1'b1 && !prev_ready) begin
        if (!last_abort) begin
          tests++;
          if (rlow != NS + 1) begin
            fails++;
            $display("FAIL ready_low: got %0d cycles, expected %0d", rlow, NS + 1);
          end
        end
        rlow = 0;
      end
      prev_frame = (frame_o === 1'b1);
      prev_ready = (ready_o !== 1'b0);
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    int n;
    rst_i = 1'b0; valid_i = 1'b1; data_i = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_q", q_o, 1'b0);
    chk("rst_frame", frame_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    valid_i = 1'b0; rst_i = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", ready_o, 1'b1);
    chk("post_rst_frame", frame_o, 1'b0);

    // Single word
    send(4'b1011, S_1011, 1'b0);
    repeat (20) @(negedge clk);

    // Ignored request during bit 1
    send(4'b1100, S_1100, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    valid_i = 1'b1; data_i = 4'b0000;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (30) @(negedge clk);

    // Back-to-back with valid held high
    wait_ready();
    valid_i = 1'b1; data_i = 4'b1001;
    push(S_1001, 1'b0, 1'b0);
    @(posedge clk);
    #1 data_i = 4'b0110;
    push(S_0110, 1'b0, 1'b1);
    n = 0;
    @(negedge clk);
    while (ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL b2b_ready: ready_o stayed low for %0d cycles", n);
    end
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (30) @(negedge clk);

    // Mid-frame reset during bit 2
    send(4'b1111, S_1111, 1'b1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("midrst_frame", frame_o, 1'b0);
    chk("midrst_q", q_o, 1'b0);
    chk("midrst_ready", ready_o, 1'b1);
    rst_i = 1'b1;
    repeat (30) @(negedge clk);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_empty: got %0d pending frames, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter. It is the sending end of the serial shift chain that the FPGA flip-flop projects clock in on `d_i`. The block accepts a `WIDTH`-bit word through a valid/ready handshake. It then shifts the word out on `q_o`, one bit per slow tick from an internal clock-enable divider, and frames the transfer with `frame_o` and `done_o`. It sits between board switches or logic and the receiving shift register.

## Interface
Parameters:
- `WIDTH`, 4, word length in bits; minimum 2.
- `DIV`, 25000000, `clk_i` cycles per serial bit; minimum 1.

Ports:
- `clk_i`  in  1  system clock; the only clock in the block.
- `rst_i`  in  1  reset, synchronous, active-low.
- `data_i`  in  `WIDTH`  parallel word; sampled only on accept.
- `valid_i`  in  1  word request.
- `ready_o`  out  1  high in IDLE; the block can accept a word.
- `q_o`  out  1  serial data; 0 when no word is being sent.
- `frame_o`  out  1  high while a word's bits are on `q_o`.
- `done_o`  out  1  one-cycle pulse after the last bit completes.

## Operation
Reset:
- When `rst_i`=0 at a `clk_i` edge: state=IDLE, shift register=0, bit counter=0, divider counter=0.
- Output values after that edge: `ready_o`=1, `q_o`=0, `frame_o`=0, `done_o`=0.
- Reset takes priority over every other event.

Divider:
- Counter runs 0..`DIV`-1 and is cleared on accept.
- `tick` = (counter==`DIV`-1). With `DIV`=1, `tick` is true every cycle.
- No derived clocks; `tick` is used only as an enable.

State machine:
- IDLE: `ready_o`=1. An accept is `valid_i`&`ready_o` at an edge. On accept: load the shift register from `data_i`, clear the bit counter and divider, go to SHIFT.
- SHIFT: `frame_o`=1, `ready_o`=0, `q_o` = current output bit of the shift register. On `tick`:
  - If bit counter==`WIDTH`-1: clear the shift register and go to DONE.
  - Otherwise: shift one position and increment the bit counter.
- DONE: lasts exactly one cycle. `done_o`=1, `frame_o`=0, `q_o`=0, `ready_o`=0. Then go to IDLE.

Other rules:
- `valid_i` and `data_i` are ignored outside IDLE. There is no queueing.
- Bit counter width is clog2(`WIDTH`). It never wraps past `WIDTH`-1.
- Reset mid-frame: the partial word is abandoned and no `done_o` is produced.

## Timing
- Reference point: accept at edge E0.
- Bit k (k=0..`WIDTH`-1) is on `q_o` for cycles E0+k·`DIV` .. E0+(k+1)·`DIV`-1, exactly `DIV` cycles each.
- `frame_o` is high for exactly `WIDTH`·`DIV` cycles, starting the cycle after E0.
- `done_o` is high for the single cycle after edge E0+`WIDTH`·`DIV`.
- `ready_o` is low for `WIDTH`·`DIV`+1 cycles and returns to 1 after edge E0+`WIDTH`·`DIV`+1.
- Back-to-back with `valid_i` held high: the next accept is at edge E0+`WIDTH`·`DIV`+2. This gives a 2-cycle gap between `frame_o` falling and rising again.
- All outputs are registered or decoded from state flops only. There are no combinational paths from inputs to outputs.

## Configuration
- `PISO_LSB_FIRST_EN` defined: shift right, `q_o` = shift register bit 0, so the LSB is sent first.
- `PISO_LSB_FIRST_EN` undefined (default): shift left, `q_o` = bit `WIDTH`-1, so the MSB is sent first.
- Timing and handshake are identical in both builds.

## Test plan
All scenarios use `WIDTH`=4, `DIV`=3, MSB-first unless stated.
- Reset: hold `rst_i`=0 for 2 cycles with `valid_i`=1, `data_i`=4'b1111 -> `ready_o`=1, `q_o`=0, `frame_o`=0, `done_o`=0; no accept.
- Single word: send 4'b1011 -> `q_o` = 1,0,1,1, each bit for 3 cycles; `frame_o` high for 12 cycles; `done_o` high for 1 cycle; `ready_o` low for 13 cycles.
- Ignored request: send 4'b1100, then pulse `valid_i` with 4'b0000 during bit 1 -> only 1,1,0,0 is sent; no second frame follows.
- Back-to-back: hold `valid_i` high with 4'b1001, then switch to 4'b0110 after the first accept -> second frame starts exactly 2 cycles after `frame_o` falls; `q_o` = 0,1,1,0.
- Mid-frame reset: send 4'b1111 and assert `rst_i`=0 during bit 2 -> next edge `frame_o`=0, `q_o`=0, `ready_o`=1; `done_o` never pulses.
- Build with `PISO_LSB_FIRST_EN`, send 4'b1011 -> `q_o` = 1,1,0,1; same 12-cycle frame.
